fc_sequencer: RTL and testbench

Controller that sequences one fully-connected layer evaluation on the `mac` datapath. It accepts a framed feature stream from upstream and fetches the matching weight vector from a 1-cycle-latency weight memory. It then drives the aligned feature/weight/bias stream into `mac` with correct last framing, captures the per-class result, and hands it downstream with a valid/ready handshake. On a malformed frame it flushes the `mac` accumulators so the next frame starts clean.

---
 rtl/fc_pkg.sv | 23 ++
 rtl/fc_sequencer.sv | 162 ++++++++++++++++
 tb/tb_fc_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer sequencer and its mac datapath:
// controller states, default timing limits and the datapath bitwidth relations.
package fc_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } fc_state_e;

    localparam int FC_DRAIN_TIMEOUT = 8;
    localparam int FC_FLUSH_CYCLES  = 9;

    function automatic int bias_bw(input int i_bw);
        return 2 * i_bw;
    endfunction

    function automatic int o_bw(input int i_bw);
        return 3 * i_bw;
    endfunction

endpackage

// File: rtl/fc_sequencer.sv
// Sequences one fully-connected layer pass: streams features with their fetched
// weights into mac, captures the per-class result and hands it downstream.
module fc_sequencer
    import fc_pkg::*;
#(
    parameter int I_BW          = 8,
    parameter int BIAS_BW       = bias_bw(I_BW),
    parameter int O_BW          = o_bw(I_BW),
    parameter int NUM_CLASSES   = 3,
    parameter int NUM_INPUTS    = 208,
    parameter int ADDR_BW       = $clog2(NUM_INPUTS),
    parameter int DRAIN_TIMEOUT = FC_DRAIN_TIMEOUT,
    parameter int FLUSH_CYCLES  = FC_FLUSH_CYCLES
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [I_BW-1:0]                data_i,
    input  logic                           valid_i,
    input  logic                           last_i,
    output logic                           ready_o,
    input  logic [NUM_CLASSES*BIAS_BW-1:0] bias_i,
    output logic [ADDR_BW-1:0]             wmem_addr_o,
    output logic                           wmem_rd_o,
    input  logic [NUM_CLASSES*I_BW-1:0]    wmem_data_i,
    output logic [I_BW-1:0]                mac_data0_o,
    output logic                           mac_valid0_o,
    output logic [NUM_CLASSES*I_BW-1:0]    mac_data1_w_o,
    output logic [NUM_CLASSES*BIAS_BW-1:0] mac_data1_b_o,
    output logic                           mac_valid1_o,
    output logic                           mac_last1_o,
    input  logic [NUM_CLASSES*O_BW-1:0]    mac_data_i,
    input  logic                           mac_valid_i,
    output logic [NUM_CLASSES*O_BW-1:0]    data_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic                           frame_err_o
);

    localparam int CNT_MAX = (DRAIN_TIMEOUT > FLUSH_CYCLES) ? DRAIN_TIMEOUT : FLUSH_CYCLES;
    localparam int CNT_BW  = $clog2(CNT_MAX + 1);

    localparam logic [ADDR_BW-1:0] LAST_IDX    = ADDR_BW'(NUM_INPUTS - 1);
    localparam logic [CNT_BW-1:0]  DRAIN_LIMIT = CNT_BW'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_BW-1:0]  FLUSH_LIMIT = CNT_BW'(FLUSH_CYCLES - 1);

    fc_state_e                   state_q, state_d;
    logic [ADDR_BW-1:0]          idx_q, idx_d;
    logic [CNT_BW-1:0]           cnt_q, cnt_d;
    logic                        err_q, err_d;
    logic [I_BW-1:0]             feat_q;
    logic                        beat_q;
    logic                        last_q;
    logic [NUM_CLASSES*O_BW-1:0] result_q;

    logic accept;
    logic at_last_idx;
    logic issue_beat;
    logic capture;

    // Gated by reset so nothing is accepted while the state register is held.
    assign ready_o     = (state_q == ST_RUN) && !rst_i;
    assign accept      = valid_i && ready_o;
    assign at_last_idx = (idx_q == LAST_IDX);
    assign issue_beat  = accept && (at_last_idx || !last_i);

    assign wmem_addr_o = idx_q;
    assign wmem_rd_o   = accept;

    assign mac_data0_o   = feat_q;
    assign mac_valid0_o  = beat_q;
    assign mac_valid1_o  = beat_q;
    assign mac_last1_o   = last_q;
    assign mac_data1_w_o = beat_q ? wmem_data_i : '0;
    assign mac_data1_b_o = bias_i;

    assign data_o      = result_q;
    assign valid_o     = (state_q == ST_HOLD);
    assign frame_err_o = err_q;

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        capture = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (at_last_idx) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        err_d   = !last_i;
                        state_d = ST_DRAIN;
                    end else if (last_i) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_FLUSH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (mac_valid_i) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end else if (cnt_q == DRAIN_LIMIT) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_FLUSH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (ready_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // Keeping mac idle this long trips its valid timeout and clears any partial sums.
                if (cnt_q == FLUSH_LIMIT) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            idx_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            feat_q   <= '0;
            beat_q   <= 1'b0;
            last_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            beat_q  <= issue_beat;
            last_q  <= issue_beat && at_last_idx;
            if (issue_beat) begin
                feat_q <= data_i;
            end
            if (capture) begin
                result_q <= mac_data_i;
            end
        end
    end

endmodule

// File: tb/tb_fc_sequencer.sv
// Randomized scoreboard bench for fc_sequencer with a behavioural weight memory
// and mac model; expected results come from plain arithmetic over each frame.
module tb_fc_sequencer;

    localparam int I_BW        = 8;
    localparam int BIAS_BW     = 16;
    localparam int O_BW        = 24;
    localparam int NC          = 3;
    localparam int N           = 4;
    localparam int ADDR_BW     = 2;
    localparam int MAC_TIMEOUT = 8;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [I_BW-1:0]        data_i;
    logic                   valid_i;
    logic                   last_i;
    logic                   ready_o;
    logic [NC*BIAS_BW-1:0]  bias_i;
    logic [ADDR_BW-1:0]     wmem_addr_o;
    logic                   wmem_rd_o;
    logic [NC*I_BW-1:0]     wmem_data_i = '0;
    logic [I_BW-1:0]        mac_data0_o;
    logic                   mac_valid0_o;
    logic [NC*I_BW-1:0]     mac_data1_w_o;
    logic [NC*BIAS_BW-1:0]  mac_data1_b_o;
    logic                   mac_valid1_o;
    logic                   mac_last1_o;
    logic [NC*O_BW-1:0]     mac_data_i = '0;
    logic                   mac_valid_i = 1'b0;
    logic [NC*O_BW-1:0]     data_o;
    logic                   valid_o;
    logic                   ready_i;
    logic                   frame_err_o;

    fc_sequencer #(
        .I_BW       (I_BW),
        .NUM_CLASSES(NC),
        .NUM_INPUTS (N)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .last_i       (last_i),
        .ready_o      (ready_o),
        .bias_i       (bias_i),
        .wmem_addr_o  (wmem_addr_o),
        .wmem_rd_o    (wmem_rd_o),
        .wmem_data_i  (wmem_data_i),
        .mac_data0_o  (mac_data0_o),
        .mac_valid0_o (mac_valid0_o),
        .mac_data1_w_o(mac_data1_w_o),
        .mac_data1_b_o(mac_data1_b_o),
        .mac_valid1_o (mac_valid1_o),
        .mac_last1_o  (mac_last1_o),
        .mac_data_i   (mac_data_i),
        .mac_valid_i  (mac_valid_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- weight memory and mac models ----------------
    logic [NC*I_BW-1:0] wmem_word [N];

    always @(posedge clk_i) begin
        if (wmem_rd_o) wmem_data_i <= wmem_word[wmem_addr_o];
    end

    logic signed [O_BW-1:0] acc [NC] = '{default: '0};
    logic [NC*O_BW-1:0]     r0 = '0, r1 = '0;
    logic                   s0 = 1'b0, s1 = 1'b0;
    int                     mac_idle = 0;
    bit                     mac_mute = 1'b0;

    always @(posedge clk_i) begin
        s0          <= mac_valid0_o && mac_valid1_o && mac_last1_o;
        s1          <= s0;
        mac_valid_i <= s1 && !mac_mute;
        r1          <= r0;
        mac_data_i  <= r1;
        if (mac_valid0_o && mac_valid1_o) begin
            mac_idle <= 0;
            for (int c = 0; c < NC; c++) begin
                if (mac_last1_o) begin
                    acc[c] <= '0;
                    r0[c*O_BW +: O_BW] <= acc[c]
                        + $signed(mac_data0_o) * $signed(mac_data1_w_o[c*I_BW +: I_BW])
                        + $signed(mac_data1_b_o[c*BIAS_BW +: BIAS_BW]);
                end else begin
                    acc[c] <= acc[c]
                        + $signed(mac_data0_o) * $signed(mac_data1_w_o[c*I_BW +: I_BW]);
                end
            end
        end else begin
            if (mac_idle >= MAC_TIMEOUT - 1) begin
                for (int c = 0; c < NC; c++) acc[c] <= '0;
            end
            if (mac_idle < MAC_TIMEOUT) mac_idle <= mac_idle + 1;
        end
    end

    // ---------------- scoreboard state ----------------
    logic [NC*O_BW-1:0]  exp_q [$];
    logic [ADDR_BW-1:0]  addr_q [$];
    int                  exp_last = 0;
    int                  exp_err  = 0;
    int                  n_last   = 0;
    int                  n_errp   = 0;
    int                  model_k  = 0;
    int                  force_low = 0;
    bit                  rand_ready = 1'b0;

    // Downstream ready driver: optional forced stall while a result is held, else 1 or random.
    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            if (force_low > 0 && valid_o) begin
                ready_i = 1'b0;
                force_low--;
            end else begin
                ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // Monitor: samples mid-cycle, pops expectations whenever the DUT presents something.
    initial begin
        bit                 prev_valid = 1'b0;
        bit                 prev_stall = 1'b0;
        bit                 resume_pending = 1'b0;
        logic [NC*O_BW-1:0] prev_data = '0;
        int                 last_acc_cyc = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_valid = 1'b0;
                prev_stall = 1'b0;
                resume_pending = 1'b0;
            end else begin
                if (wmem_rd_o) begin
                    check("wmem_rd_expected", addr_q.size() > 0, 1'b1);
                    if (addr_q.size() > 0) check("wmem_addr", wmem_addr_o, addr_q.pop_front());
                end
                if (mac_last1_o) n_last++;
                if (frame_err_o) n_errp++;
                if (valid_o) check("ready_o_low_in_hold", ready_o, 1'b0);
                if (valid_o && !prev_valid) check("result_latency", cyc - last_acc_cyc, 5);
                if (prev_stall) begin
                    check("hold_valid_stable", valid_o, 1'b1);
                    check("hold_data_stable", data_o, prev_data);
                end
                if (resume_pending) check("ready_after_handshake", ready_o, 1'b1);
                if (valid_o && ready_i) begin
                    check("result_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) check("result_data", data_o, exp_q.pop_front());
                end
                if (valid_i && ready_o) last_acc_cyc = cyc;
                resume_pending = valid_o && ready_i;
                prev_valid     = valid_o;
                prev_stall     = valid_o && !ready_i;
                prev_data      = data_o;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [NC*O_BW-1:0] ref_result(input int fq[$], input int kq[$]);
        logic [NC*O_BW-1:0] res = '0;
        for (int c = 0; c < NC; c++) begin
            longint s = longint'($signed(bias_i[c*BIAS_BW +: BIAS_BW]));
            for (int i = 0; i < fq.size(); i++) begin
                s += longint'(fq[i]) * longint'($signed(wmem_word[kq[i]][c*I_BW +: I_BW]));
            end
            res[c*O_BW +: O_BW] = O_BW'(s);
        end
        return res;
    endfunction

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (ready_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_i);
            #1;
        end
        check("ready_wait_bound", ok, 1'b1);
    endtask

    task automatic drive_feature(input logic [I_BW-1:0] d, input logic lst);
        wait_ready();
        data_i  = d;
        last_i  = lst;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    // kind: 0 normal, 1 missing last, 2 early last at early_pos, 3 normal with mac silent
    task automatic send_frame(input int kind, input int early_pos, input int gmin, input int gmax,
                              input bit directed, input int bp_cycles);
        int fq[$];
        int kq[$];
        int n_feat;
        logic [I_BW-1:0] f;
        logic lst;
        wait_ready();
        mac_mute  = (kind == 3);
        force_low = bp_cycles;
        for (int k = 0; k < N; k++)
            for (int c = 0; c < NC; c++)
                wmem_word[k][c*I_BW +: I_BW] = directed ? I_BW'(c + 1) : I_BW'($urandom);
        for (int c = 0; c < NC; c++)
            bias_i[c*BIAS_BW +: BIAS_BW] = directed ? BIAS_BW'(10 * (c + 1)) : BIAS_BW'($urandom);
        n_feat = (kind == 2) ? early_pos + 1 : N;
        for (int i = 0; i < n_feat; i++) begin
            f   = directed ? I_BW'(i + 1) : I_BW'($urandom);
            lst = ((kind == 0 || kind == 3) && i == N - 1) || (kind == 2 && i == early_pos);
            addr_q.push_back(ADDR_BW'(model_k));
            fq.push_back(int'($signed(f)));
            kq.push_back(model_k);
            drive_feature(f, lst);
            if (kind == 2 && i == early_pos) begin
                model_k = 0;
                exp_err++;
            end else begin
                model_k = (model_k + 1) % N;
            end
            if (i < n_feat - 1) repeat ($urandom_range(gmin, gmax)) begin
                @(posedge clk_i);
                #1;
            end
        end
        if (kind != 2) begin
            exp_last++;
            if (kind == 3) exp_err++;
            else exp_q.push_back(ref_result(fq, kq));
            if (kind == 1) exp_err++;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready_o"}, ready_o, 1'b0);
        check({tag, "_valid_o"}, valid_o, 1'b0);
        check({tag, "_data_o"}, data_o, '0);
        check({tag, "_mac_valid"}, {mac_valid0_o, mac_valid1_o, mac_last1_o}, 3'b000);
        check({tag, "_mac_data"}, {mac_data0_o, mac_data1_w_o}, '0);
        check({tag, "_wmem"}, {wmem_rd_o, wmem_addr_o}, '0);
        check({tag, "_frame_err_o"}, frame_err_o, 1'b0);
    endtask

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'h5a;
        last_i  = 1'b0;
        bias_i  = '0;
        for (int k = 0; k < N; k++) wmem_word[k] = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check_zero_outputs("reset");
        valid_i = 1'b0;
        rst_i   = 1'b0;
        @(posedge clk_i);
        #1;

        // normal frame, then forced backpressure, then bubbles of two cycles
        send_frame(0, 0, 0, 0, 1'b1, 0);
        send_frame(0, 0, 0, 0, 1'b1, 6);
        send_frame(0, 0, 2, 2, 1'b1, 0);
        // early last on the 2nd feature, then a clean frame
        send_frame(2, 1, 0, 0, 1'b1, 0);
        send_frame(0, 0, 0, 1, 1'b0, 0);
        // missing last, then mac result never arrives
        send_frame(1, 0, 0, 1, 1'b0, 0);
        send_frame(3, 0, 0, 0, 1'b0, 0);
        send_frame(0, 0, 0, 0, 1'b0, 0);

        // reset after two accepts
        wait_ready();
        addr_q.push_back(ADDR_BW'(0));
        drive_feature(8'd7, 1'b0);
        addr_q.push_back(ADDR_BW'(1));
        drive_feature(8'd9, 1'b0);
        #3;
        rst_i = 1'b1;
        #1;
        check_zero_outputs("midreset");
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        model_k = 0;
        repeat (10) begin
            @(posedge clk_i);
            #1;
        end
        send_frame(0, 0, 0, 0, 1'b1, 0);

        // randomized mix with random downstream ready
        rand_ready = 1'b1;
        for (int r = 0; r < 24; r++) begin
            int sel = $urandom_range(0, 9);
            int kind = (sel < 6) ? 0 : (sel < 8) ? 1 : 2;
            send_frame(kind, $urandom_range(0, N - 2), 0, 3, 1'b0, 0);
        end

        begin
            bit drained = 1'b0;
            for (int n = 0; n < 400; n++) begin
                if (exp_q.size() == 0) begin
                    drained = 1'b1;
                    break;
                end
                @(posedge clk_i);
                #1;
            end
            check("scoreboard_drained", drained, 1'b1);
        end
        repeat (5) @(posedge clk_i);
        #1;
        check("mac_last_count", n_last, exp_last);
        check("frame_err_count", n_errp, exp_err);
        check("addr_queue_empty", addr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
